fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
// - Read-side drain engine for a standard (non-FWFT) synchronous FIFO.
// - Issues rd_en pulses, tracks in-flight reads over a fixed read latency and
//   captures returned words into a small prefetch buffer.
// - Presents the buffered words as a valid/ready stream with zero bubbles.
// - Sits between any FIFO read port and a downstream valid/ready consumer.
// PARAMETERS
// - DATA_WIDTH  8   word width
// - RD_LATENCY  1   cycles from fifo_rd_en high to fifo_rd_data valid (1..4)
// - BUF_DEPTH   RD_LATENCY+2   prefetch entries; derived, do not override
// PORTS
// - clk           in   1           clock, all logic rising-edge
// - rst           in   1           synchronous reset, active-high
// - fifo_empty    in   1           upstream FIFO empty flag
// - fifo_rd_en    out  1           read strobe to upstream FIFO
// - fifo_rd_data  in   DATA_WIDTH  read data, valid RD_LATENCY cycles after rd_en
// - m_valid       out  1           stream word available
// - m_ready       in   1           consumer accepts word
// - m_data        out  DATA_WIDTH  stream word (buffer head)
// - busy          out  1           words buffered or reads in flight
// BEHAVIOUR
// - Reset (rst=1 at clk edge): occupancy=0, inflight pipe cleared, both pointers=0.
//   During rst fifo_rd_en=0, m_valid=0, busy=0, m_data=0.
// - State: buffer occupancy occ (0..BUF_DEPTH), inflight count infl (0..RD_LATENCY),
//   valid shift register vpipe[RD_LATENCY], circular buffer with wr_ptr/rd_ptr.
// - Issue rule (comb.): fifo_rd_en = !rst && !fifo_empty && (occ+infl) < BUF_DEPTH.
//   occ and infl are registered values; no comb. path from m_ready to fifo_rd_en.
// - vpipe[0] <= fifo_rd_en; vpipe shifts each cycle. When vpipe[RD_LATENCY-1]=1,
//   fifo_rd_data is written at wr_ptr, wr_ptr advances.
// - Pop: m_valid && m_ready -> rd_ptr advances. m_valid = (occ != 0).
//   m_data = buf[rd_ptr]; must hold stable while m_valid && !m_ready.
// - Pointers wrap from BUF_DEPTH-1 to 0 explicitly (BUF_DEPTH need not be 2^n).
// - Simultaneous capture and pop: occ unchanged; both pointers advance.
//   Capture with occ=0 and m_ready=1: word appears on m_data next cycle (no bypass).
// - Throughput: with m_ready held 1 and fifo_empty held 0, one word per cycle
//   after initial fill latency of RD_LATENCY+1 cycles (rd_en to first m_valid).
// - Overflow impossible by construction (occ+infl <= BUF_DEPTH); bench asserts
//   occ <= BUF_DEPTH and never capture when occ=BUF_DEPTH and no pop.
// - busy = (occ != 0) || (infl != 0).
// - Reset mid-operation: in-flight returns and buffered words are discarded;
//   upstream FIFO must be reset in the same cycle, data loss is by design.
// - fifo_empty sampled only in the issue rule; a FIFO going empty with reads in
//   flight is legal, those reads still complete.
// TESTING
// - Reset: rst=1 for 3 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, busy=0.
// - Single word, RD_LATENCY=1: FIFO holds 0xA5, m_ready=1 -> rd_en at t0,
//   m_valid=1 with m_data=0xA5 at t2, m_valid=0 at t3.
// - Streaming: FIFO holds 0x00..0x3F, m_ready=1 -> 64 words in order on
//   64 consecutive cycles, no bubbles, for RD_LATENCY=1 and 3.
// - Backpressure: m_ready=0 with FIFO non-empty -> exactly BUF_DEPTH rd_en pulses,
//   m_data holds first word; release -> all words in order, none lost/duplicated.
// - Random m_ready (50%) and random fifo_empty gaps, 1000 words -> scoreboard
//   match, occ never exceeds BUF_DEPTH, pointer wrap exercised.
// - Mid-stream reset with 2 words buffered and 1 in flight -> next cycle m_valid=0,
//   busy=0; late-returning data not captured.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine for a non-FWFT synchronous FIFO: issues reads against a
// fixed read latency and re-presents the returned words as a bubble-free valid/ready stream.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy
);

   localparam int BUF_DEPTH = RD_LATENCY + 2;
   localparam int PW        = $clog2(BUF_DEPTH);
   localparam int CW        = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         occ_q, occ_d;
   logic [CW-1:0]         infl_q, infl_d;
   logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
   logic [CW:0]           pending;
   logic                  capture;
   logic                  pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Issue decision uses only registered occupancy, so m_ready never reaches fifo_rd_en.
   always_comb begin
      pending    = {1'b0, occ_q} + {1'b0, infl_q};
      fifo_rd_en = !rst && !fifo_empty && (pending < DEPTH_C);
      capture    = vpipe_q[RD_LATENCY-1];
      m_valid    = !rst && (occ_q != '0);
      pop        = m_valid && m_ready;
      m_data     = rst ? '0 : mem_q[rd_ptr_q];
      busy       = !rst && ((occ_q != '0) || (infl_q != '0));
      vpipe_d    = RD_LATENCY'({vpipe_q, fifo_rd_en});
      infl_d     = infl_q + CW'(fifo_rd_en) - CW'(capture);
      occ_d      = occ_q + CW'(capture) - CW'(pop);
      wr_ptr_d   = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q    <= '0;
         infl_q   <= '0;
         vpipe_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         occ_q    <= occ_d;
         infl_q   <= infl_d;
         vpipe_q  <= vpipe_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: a slot is only presented after it has been written.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         mem_q[wr_ptr_q] <= fifo_rd_data;
      end
   end

endmodule
